dht_responder: RTL and testbench
================================

Name: dht_responder

Overview:
- Single-wire humidity/temperature sensor emulator: the responder (sensor) end of the DHT-style protocol the Humidity reader drives as host on Data_H.
- Detects the host start pulse, answers with the ACK preamble, then sends a 40-bit frame: 16 b humidity, 16 b temperature, 8 b checksum, MSB first.
- Used for hardware-in-loop self-test of the Humidity path and as a bench model; runs on clk1M (1 tick = 1 us).

Parameters:
- START_MIN_US, 800, minimum host low time (us) accepted as a start request.
- RESP_DLY_US, 30, wait after host releases the line before the ACK.
- ACK_LOW_US, 80, ACK low phase.
- ACK_HIGH_US, 80, ACK released phase.
- BIT_LOW_US, 50, low lead-in of every bit and of the trailing end pulse.
- ZERO_HIGH_US, 26, released time encoding '0'.
- ONE_HIGH_US, 70, released time encoding '1'.
- CNT_W, 16, width of the us timer.

Ports:
- clk1M  in  1  1 MHz clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  1  line level read from Data_H pad.
- data_oe  out  1  1 = pull line low (open-drain); top level drives Data_H = data_oe ? 0 : 'z'.
- frame_we  in  1  one-cycle load strobe for frame_data.
- frame_data  in  32  {humidity[15:0], temperature[15:0]}.
- busy  out  1  high from start detection until return to IDLE.
- done  out  1  one-cycle pulse after a complete frame.
- err  out  1  one-cycle pulse on an aborted transfer.

Behaviour:
- Reset: data_oe=0, busy=0, done=0, err=0, holding register=0, state=IDLE, synchroniser flops=1. Reset mid-transfer releases the line immediately.
- data_in passes through a 2-flop synchroniser (2 cycles latency); all decisions use the synchronised value ds.
- Holding register loads on frame_we in any state. It is copied to a 40-bit shift register, with checksum = (h_hi+h_lo+t_hi+t_lo) mod 256, on entry to ACK_LOW. A write during a transfer affects only the next frame.
- The timer clears on every state entry and increments by 1 per cycle, saturating at all-ones.
- IDLE: when ds=0, go to HOST_LOW; busy=0.
- HOST_LOW: count while ds=0. On ds=1:
  - if count>=START_MIN_US, go to RESP_DLY and set busy=1;
  - otherwise return to IDLE with no response and no err.
- RESP_DLY: hold data_oe=0 for RESP_DLY_US cycles, then go to ACK_LOW.
- ACK_LOW: data_oe=1 for ACK_LOW_US cycles, then ACK_HIGH.
- ACK_HIGH: data_oe=0 for ACK_HIGH_US cycles, then BIT_LOW with bit index 39.
- BIT_LOW: data_oe=1 for BIT_LOW_US cycles, then BIT_HIGH.
- BIT_HIGH: data_oe=0 for ZERO_HIGH_US or ONE_HIGH_US cycles, according to the current MSB. Then shift left:
  - if index>0, decrement it and go to BIT_LOW;
  - otherwise go to END_LOW.
- END_LOW: data_oe=1 for BIT_LOW_US cycles, then release, pulse done, go to IDLE.
- Collision detect: in any released phase (ACK_HIGH, BIT_HIGH), from the 3rd cycle after release onward, ds=0 counts as a collision. On collision: pulse err, data_oe=0, go to IDLE.
- Phase durations are exact to the cycle: data_oe edges are registered, with no extra pipeline delay beyond one flop.
- A new start pulse is only recognised in IDLE.

Optional Feature:
- Macro DHT_FAULT_INJECT_EN.
- With it: adds port fault_cks (in, 1). If fault_cks=1 when the frame is snapshotted at ACK_LOW entry, the transmitted checksum has bit 0 inverted. Used to exercise the Humidity reader's checksum-reject path.
- Without it: the port is absent and the checksum is always correct.

Decomposition:
- Shared package dht_pkg: state enum (IDLE, HOST_LOW, RESP_DLY, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW), FRAME_BITS=40, and the default timing constants reused by the Humidity reader.
- One natural sub-module: dht_sync2 (2-flop synchroniser with reset value 1).

Test Plan:
- Load 0x0292010C; host low 1000 us, then release -> after 2+30 cycles, 80 low / 80 high. Bits decode to 0x0292010CA1; done after the 50 us end pulse; data_oe=0 thereafter.
- Host low 500 us -> no data_oe assertion, busy stays 0, no err.
- frame_we with 0x12345678 during bit 10 of a 0x0292010C frame -> current frame finishes as 0x0292010CA1. The next frame is 0x1234567814 (0x12+0x34+0x56+0x78=0x114, mod 256 = 0x14).
- Host forces line low 10 us into the BIT_HIGH of bit 5 -> err pulse within 3 cycles, data_oe=0, state IDLE, no done.
- rst_n asserted during ACK_LOW -> data_oe=0 the same cycle (async); after release, a new 1000 us start yields a normal frame.
- With DHT_FAULT_INJECT_EN, fault_cks=1, frame 0x0292010C -> checksum byte 0xA0.

Source files
------------

// File: rtl/dht_pkg.sv
// Shared definitions for the DHT single-wire responder and host reader.
// State encoding, frame size, default protocol timing and checksum helper.
package dht_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOST_LOW,
        RESP_DLY,
        ACK_LOW,
        ACK_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } dht_state_t;

    localparam int FRAME_BITS = 40;

    localparam int DEF_START_MIN_US = 800;
    localparam int DEF_RESP_DLY_US  = 30;
    localparam int DEF_ACK_LOW_US   = 80;
    localparam int DEF_ACK_HIGH_US  = 80;
    localparam int DEF_BIT_LOW_US   = 50;
    localparam int DEF_ZERO_HIGH_US = 26;
    localparam int DEF_ONE_HIGH_US  = 70;

    function automatic logic [7:0] frame_cks(input logic [31:0] v);
        return v[31:24] + v[23:16] + v[15:8] + v[7:0];
    endfunction

endpackage

// File: rtl/dht_sync2.sv
// Two-flop synchroniser for the Data_H line; resets to the idle-high level.
module dht_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            q  <= 1'b1;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/dht_responder.sv
// DHT-style sensor emulator: answers a host start pulse with ACK and a 40-bit frame.
// Optional DHT_FAULT_INJECT_EN adds fault_cks to corrupt checksum bit 0.
module dht_responder
    import dht_pkg::*;
#(
    parameter int START_MIN_US = DEF_START_MIN_US,
    parameter int RESP_DLY_US  = DEF_RESP_DLY_US,
    parameter int ACK_LOW_US   = DEF_ACK_LOW_US,
    parameter int ACK_HIGH_US  = DEF_ACK_HIGH_US,
    parameter int BIT_LOW_US   = DEF_BIT_LOW_US,
    parameter int ZERO_HIGH_US = DEF_ZERO_HIGH_US,
    parameter int ONE_HIGH_US  = DEF_ONE_HIGH_US,
    parameter int CNT_W        = 16
) (
    input  logic        clk1M,
    input  logic        rst_n,
`ifdef DHT_FAULT_INJECT_EN
    input  logic        fault_cks,
`endif
    input  logic        data_in,
    output logic        data_oe,
    input  logic        frame_we,
    input  logic [31:0] frame_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // The IDLE cycle that spots the falling edge is part of the host low time.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_MIN_US - 1);
    localparam logic [CNT_W-1:0] RESP_LAST  = CNT_W'(RESP_DLY_US - 1);
    localparam logic [CNT_W-1:0] ACKL_LAST  = CNT_W'(ACK_LOW_US - 1);
    localparam logic [CNT_W-1:0] ACKH_LAST  = CNT_W'(ACK_HIGH_US - 1);
    localparam logic [CNT_W-1:0] BITL_LAST  = CNT_W'(BIT_LOW_US - 1);
    localparam logic [CNT_W-1:0] ZERO_LAST  = CNT_W'(ZERO_HIGH_US - 1);
    localparam logic [CNT_W-1:0] ONE_LAST   = CNT_W'(ONE_HIGH_US - 1);
    localparam logic [CNT_W-1:0] SETTLE     = CNT_W'(2);

    dht_state_t state, state_nxt;

    logic                  ds;
    logic [CNT_W-1:0]      cnt;
    logic [31:0]           hold;
    logic [FRAME_BITS-1:0] sr;
    logic [5:0]            idx;
    logic [7:0]            cks;
    logic [CNT_W-1:0]      hi_last;
    logic                  released;
    logic                  collide;
    logic                  oe_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;
    logic                  err_nxt;

    dht_sync2 u_sync (
        .clk   (clk1M),
        .rst_n (rst_n),
        .d     (data_in),
        .q     (ds)
    );

`ifdef DHT_FAULT_INJECT_EN
    assign cks = frame_cks(hold) ^ {7'd0, fault_cks};
`else
    assign cks = frame_cks(hold);
`endif

    assign hi_last = sr[FRAME_BITS-1] ? ONE_LAST : ZERO_LAST;

    // Our own release needs two sync cycles to reach ds before low means the host.
    assign released = (state == ACK_HIGH) || (state == BIT_HIGH);
    assign collide  = released && (cnt >= SETTLE) && !ds;

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            data_oe <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            data_oe <= oe_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:
                if (!ds) state_nxt = HOST_LOW;
            HOST_LOW:
                if (ds) state_nxt = (cnt >= START_LAST) ? RESP_DLY : IDLE;
            RESP_DLY:
                if (cnt == RESP_LAST) state_nxt = ACK_LOW;
            ACK_LOW:
                if (cnt == ACKL_LAST) state_nxt = ACK_HIGH;
            ACK_HIGH:
                if (collide) state_nxt = IDLE;
                else if (cnt == ACKH_LAST) state_nxt = BIT_LOW;
            BIT_LOW:
                if (cnt == BITL_LAST) state_nxt = BIT_HIGH;
            BIT_HIGH:
                if (collide) state_nxt = IDLE;
                else if (cnt == hi_last)
                    state_nxt = (idx == 6'd0) ? END_LOW : BIT_LOW;
            END_LOW:
                if (cnt == BITL_LAST) state_nxt = IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        oe_nxt   = state_nxt inside {ACK_LOW, BIT_LOW, END_LOW};
        busy_nxt = !(state_nxt inside {IDLE, HOST_LOW});
        done_nxt = (state == END_LOW) && (state_nxt == IDLE);
        err_nxt  = collide;
    end

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
        end else if (frame_we) begin
            hold <= frame_data;
        end
    end

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            idx <= '0;
        end else begin
            if (state == RESP_DLY && state_nxt == ACK_LOW) begin
                sr <= {hold, cks};
            end else if (state == BIT_HIGH &&
                         state_nxt inside {BIT_LOW, END_LOW}) begin
                sr <= {sr[FRAME_BITS-2:0], 1'b0};
            end
            if (state == ACK_HIGH && state_nxt == BIT_LOW) begin
                idx <= 6'(FRAME_BITS - 1);
            end else if (state == BIT_HIGH && state_nxt == BIT_LOW) begin
                idx <= idx - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dht_responder.sv
// Self-checking bench for dht_responder: host model on an open-drain line,
// frame receiver decoding pulse widths, and a queue of expected frames.
module tb_dht_responder;

    logic        clk1M = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_in;
    logic        data_oe;
    logic        frame_we = 1'b0;
    logic [31:0] frame_data = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic        host_pull = 1'b0;
`ifdef DHT_FAULT_INJECT_EN
    logic        fault_cks = 1'b0;
`endif

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    logic [31:0] hold_model = '0;
    logic [39:0] exp_q[$];

    typedef struct {
        int          lat;
        int          ack_lo;
        int          ack_hi;
        int          nbad;
        int          end_lo;
        bit          done_ok;
        bit          busy_ok;
        bit          to;
        logic [39:0] bits;
    } rx_t;

    dht_responder dut (
        .clk1M      (clk1M),
        .rst_n      (rst_n),
`ifdef DHT_FAULT_INJECT_EN
        .fault_cks  (fault_cks),
`endif
        .data_in    (data_in),
        .data_oe    (data_oe),
        .frame_we   (frame_we),
        .frame_data (frame_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk1M = ~clk1M;

    // Open-drain wire: either side pulling wins.
    assign data_in = !(host_pull || data_oe);

    always @(negedge clk1M) if (done === 1'b1) done_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: sim time exceeded limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] cks(input logic [31:0] v);
        cks = v[31:24] + v[23:16] + v[15:8] + v[7:0];
    endfunction

    task automatic load(input logic [31:0] v);
        frame_data = v;
        frame_we   = 1'b1;
        @(negedge clk1M);
        frame_we   = 1'b0;
        hold_model = v;
    endtask

    task automatic host_start(input int us);
        host_pull = 1'b1;
        repeat (us) @(negedge clk1M);
        host_pull = 1'b0;
    endtask

    task automatic count_level(input logic lvl, input int lim, output int n);
        n = 0;
        while (data_oe === lvl && n < lim) begin
            @(negedge clk1M);
            n++;
        end
    endtask

    task automatic rx_frame(input int wr_bit, input logic [31:0] wr_val,
                            input int stop_bit, output rx_t r);
        int n;
        r = '{default: 0};
        n = 0;
        while (data_oe !== 1'b1 && n < 2000) begin
            @(negedge clk1M);
            n++;
        end
        r.lat = n;
        if (data_oe !== 1'b1) begin
            r.to = 1'b1;
            return;
        end
        r.busy_ok = (busy === 1'b1);
        count_level(1'b1, 1000, r.ack_lo);
        count_level(1'b0, 1000, r.ack_hi);
        for (int i = 0; i < 40; i++) begin
            if (i == wr_bit) begin
                frame_data = wr_val;
                frame_we   = 1'b1;
                fork
                    begin
                        @(posedge clk1M);
                        #1 frame_we = 1'b0;
                    end
                join_none
                hold_model = wr_val;
            end
            count_level(1'b1, 1000, n);
            if (n != 50) r.nbad++;
            if (i == stop_bit) return;
            count_level(1'b0, 1000, n);
            if (n != 26 && n != 70) r.nbad++;
            r.bits = {r.bits[38:0], (n > 48)};
        end
        count_level(1'b1, 1000, r.end_lo);
        r.done_ok = (done === 1'b1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk1M);
        total++;
        if (data_oe !== 1'b0) begin
            bad++;
            $display("FAIL reset_oe: got %b want 0", data_oe);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        total++;
        if (done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_pulses: done=%b err=%b want 0 0", done, err);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk1M);
    endtask

    task automatic test_frame;
        rx_t         r;
        logic [39:0] exp;
        load(32'h0292010C);
        exp_q.push_back({hold_model, cks(hold_model)});
        host_start(1000);
        rx_frame(-1, '0, -1, r);
        exp = exp_q.pop_front();
        total++;
        if (r.to) begin
            bad++;
            $display("FAIL frame_timeout: no ACK after %0d cycles", r.lat);
        end
        // release edge + 2 sync cycles + 30 us delay
        total++;
        if (r.lat != 33) begin
            bad++;
            $display("FAIL frame_latency: got %0d want 33", r.lat);
        end
        total++;
        if (!r.busy_ok) begin
            bad++;
            $display("FAIL frame_busy: got 0 want 1 during ACK");
        end
        total++;
        if (r.ack_lo != 80 || r.ack_hi != 80) begin
            bad++;
            $display("FAIL frame_ack: got %0d/%0d want 80/80", r.ack_lo, r.ack_hi);
        end
        total++;
        if (r.nbad != 0) begin
            bad++;
            $display("FAIL frame_bit_timing: got %0d bad phases want 0", r.nbad);
        end
        total++;
        if (r.end_lo != 50 || !r.done_ok) begin
            bad++;
            $display("FAIL frame_end: got %0d done=%b want 50 1", r.end_lo, r.done_ok);
        end
        total++;
        if (r.bits !== exp) begin
            bad++;
            $display("FAIL frame_data: got %h want %h", r.bits, exp);
        end
        repeat (20) @(negedge clk1M);
        total++;
        if (data_oe !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL frame_after: oe=%b busy=%b want 0 0", data_oe, busy);
        end
    endtask

    task automatic test_short_start;
        bit saw_oe;
        bit saw_busy;
        bit saw_err;
        saw_oe   = 1'b0;
        saw_busy = 1'b0;
        saw_err  = 1'b0;
        host_start(500);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk1M);
            if (data_oe === 1'b1) saw_oe = 1'b1;
            if (busy === 1'b1) saw_busy = 1'b1;
            if (err === 1'b1) saw_err = 1'b1;
        end
        total++;
        if (saw_oe) begin
            bad++;
            $display("FAIL short_oe: got asserted want never");
        end
        total++;
        if (saw_busy) begin
            bad++;
            $display("FAIL short_busy: got 1 want 0");
        end
        total++;
        if (saw_err) begin
            bad++;
            $display("FAIL short_err: got pulse want none");
        end
    endtask

    task automatic test_back_to_back;
        rx_t         r;
        logic [39:0] exp;
        load(32'h0292010C);
        exp_q.push_back({hold_model, cks(hold_model)});
        host_start(1000);
        rx_frame(10, 32'h12345678, -1, r);
        exp = exp_q.pop_front();
        total++;
        if (r.to || r.bits !== exp || r.nbad != 0) begin
            bad++;
            $display("FAIL b2b_first: got %h bad=%0d want %h", r.bits, r.nbad, exp);
        end
        repeat (50) @(negedge clk1M);
        exp_q.push_back({hold_model, cks(hold_model)});
        host_start(1000);
        rx_frame(-1, '0, -1, r);
        exp = exp_q.pop_front();
        total++;
        if (r.to || r.bits !== exp || r.nbad != 0) begin
            bad++;
            $display("FAIL b2b_second: got %h bad=%0d want %h", r.bits, r.nbad, exp);
        end
        total++;
        if (!r.done_ok) begin
            bad++;
            $display("FAIL b2b_done: got 0 want 1");
        end
        repeat (20) @(negedge clk1M);
    endtask

    task automatic test_collision;
        rx_t r;
        int  n;
        int  d0;
        load(32'h0292010C);
        host_start(1000);
        d0 = done_cnt;
        rx_frame(-1, '0, 5, r);
        repeat (9) @(negedge clk1M);
        host_pull = 1'b1;
        n = 0;
        while (err !== 1'b1 && n < 6) begin
            @(negedge clk1M);
            n++;
        end
        total++;
        if (err !== 1'b1 || n > 3) begin
            bad++;
            $display("FAIL coll_err: got err=%b after %0d want 1 within 3", err, n);
        end
        total++;
        if (data_oe !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL coll_release: oe=%b busy=%b want 0 0", data_oe, busy);
        end
        repeat (5) @(negedge clk1M);
        host_pull = 1'b0;
        repeat (200) @(negedge clk1M);
        total++;
        if (done_cnt != d0 || data_oe !== 1'b0) begin
            bad++;
            $display("FAIL coll_nodone: got %0d dones oe=%b want 0 0", done_cnt - d0, data_oe);
        end
    endtask

    task automatic test_reset_mid;
        rx_t         r;
        logic [39:0] exp;
        int          n;
        load(32'h0292010C);
        host_start(1000);
        n = 0;
        while (data_oe !== 1'b1 && n < 100) begin
            @(negedge clk1M);
            n++;
        end
        total++;
        if (data_oe !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_ack: got oe=%b want 1", data_oe);
        end
        repeat (10) @(negedge clk1M);
        rst_n = 1'b0;
        #1;
        total++;
        if (data_oe !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async: oe=%b busy=%b want 0 0", data_oe, busy);
        end
        @(negedge clk1M);
        rst_n = 1'b1;
        hold_model = '0;
        repeat (3) @(negedge clk1M);
        load(32'h0292010C);
        exp_q.push_back({hold_model, cks(hold_model)});
        host_start(1000);
        rx_frame(-1, '0, -1, r);
        exp = exp_q.pop_front();
        total++;
        if (r.to || r.bits !== exp || r.nbad != 0 || !r.done_ok) begin
            bad++;
            $display("FAIL rstmid_frame: got %h done=%b want %h", r.bits, r.done_ok, exp);
        end
        repeat (20) @(negedge clk1M);
    endtask

`ifdef DHT_FAULT_INJECT_EN
    task automatic test_fault;
        rx_t         r;
        logic [39:0] exp;
        fault_cks = 1'b1;
        load(32'h0292010C);
        exp_q.push_back({hold_model, cks(hold_model) ^ 8'h01});
        host_start(1000);
        rx_frame(-1, '0, -1, r);
        exp = exp_q.pop_front();
        fault_cks = 1'b0;
        total++;
        if (r.to || r.bits !== exp) begin
            bad++;
            $display("FAIL fault_cks: got %h want %h", r.bits, exp);
        end
        repeat (20) @(negedge clk1M);
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_short_start();
        test_back_to_back();
        test_collision();
        test_reset_mid();
`ifdef DHT_FAULT_INJECT_EN
        test_fault();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
